ica_iter_ctrl: RTL

- Iteration controller sitting directly downstream of the error/convergence stage in the FastICA datapath.
- Consumes that stage's selected 4x4 weight matrix, isConverge and error_busy.
- Feeds the previous-iteration matrix (w_ica) back to the update engine and the error stage, and launches each new iteration.
- Terminates the run on convergence or on reaching the iteration limit, and presents the final matrix.

---
 rtl/ica_pkg.sv | 38 +++
 rtl/ica_iter_ctrl_if.sv | 33 +++
 rtl/ica_weight_reg.sv | 35 +++
 rtl/ica_iter_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/ica_pkg.sv
// ica_pkg -- shared types and constants for the FastICA iteration controller.
package ica_pkg;

  // Default width of one signed fixed-point weight element.
  localparam int ICA_DATA_W = 26;

  // Controller state encoding.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    DECIDE    = 3'd4,
    DONE      = 3'd5
  } state_t;

  // Row-major flat index of each element of the 4x4 weight matrix.
  localparam int IDX11 = 0;
  localparam int IDX12 = IDX11 + 1;
  localparam int IDX13 = IDX12 + 1;
  localparam int IDX14 = IDX13 + 1;
  localparam int IDX21 = IDX14 + 1;
  localparam int IDX22 = IDX21 + 1;
  localparam int IDX23 = IDX22 + 1;
  localparam int IDX24 = IDX23 + 1;
  localparam int IDX31 = IDX24 + 1;
  localparam int IDX32 = IDX31 + 1;
  localparam int IDX33 = IDX32 + 1;
  localparam int IDX34 = IDX33 + 1;
  localparam int IDX41 = IDX34 + 1;
  localparam int IDX42 = IDX41 + 1;
  localparam int IDX43 = IDX42 + 1;
  localparam int IDX44 = IDX43 + 1;

  // Number of elements in one matrix.
  localparam int N_W = IDX44 + 1;

endpackage

// File: rtl/ica_iter_ctrl_if.sv
// ica_iter_ctrl_if -- bundle between the error stage / host and the
// iteration controller. Matrices are flattened row-major (see ica_pkg IDXrc).
interface ica_iter_ctrl_if #(
  parameter int DATA_W = 26,
  parameter int ITER_W = 8
);
  import ica_pkg::*;

  logic                     start;
  logic signed [DATA_W-1:0] w_init [N_W];
  logic signed [DATA_W-1:0] w      [N_W];
  logic                     isConverge;
  logic                     error_busy;
  logic                     en_update;
  logic signed [DATA_W-1:0] w_ica  [N_W];
  logic [ITER_W-1:0]        iter_cnt;
  logic                     busy;
  logic                     done;
  logic                     converged;
  logic                     fault;

  // Host / error-stage side.
  modport master (
    output start, w_init, w, isConverge, error_busy,
    input  en_update, w_ica, iter_cnt, busy, done, converged, fault
  );

  // Controller side.
  modport slave (
    input  start, w_init, w, isConverge, error_busy,
    output en_update, w_ica, iter_cnt, busy, done, converged, fault
  );
endinterface

// File: rtl/ica_weight_reg.sv
// ica_weight_reg -- 16-element signed weight register bank with a 2:1
// load mux (initial vs alternate matrix) and a common load enable.
module ica_weight_reg
  import ica_pkg::*;
#(
  parameter int DATA_W = ICA_DATA_W
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_load,
  input  logic                     i_sel_init,
  input  logic signed [DATA_W-1:0] i_d_init [N_W],
  input  logic signed [DATA_W-1:0] i_d_alt  [N_W],
  output logic signed [DATA_W-1:0] o_q      [N_W]
);

  genvar gi;
  generate
    for (gi = IDX11; gi <= IDX44; gi++) begin : g_elem
      logic signed [DATA_W-1:0] r_q;

      // Element register: cleared on reset, loaded from the selected source.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_q <= '0;
        end else if (i_load) begin
          r_q <= i_sel_init ? i_d_init[gi] : i_d_alt[gi];
        end
      end

      assign o_q[gi] = r_q;
    end
  endgenerate

endmodule

// File: rtl/ica_iter_ctrl.sv
// ica_iter_ctrl -- FastICA iteration controller: launches update iterations,
// feeds back the previous matrix and stops on convergence or MAX_ITER.
// Optional feature: define ICA_WATCHDOG_EN to abort a wait state that lasts
// WDOG_CYC cycles (fault = 1); without it the waits are unbounded.
module ica_iter_ctrl
  import ica_pkg::*;
#(
  parameter int DATA_W   = ICA_DATA_W,
  parameter int MAX_ITER = 64,
  parameter int ITER_W   = 8,
  parameter int WDOG_CYC = 4096
) (
  input logic            clk_iter,
  input logic            rstn_iter,
  ica_iter_ctrl_if.slave bus
);

  // Reject configurations where iter_cnt could wrap or the watchdog is empty.
  if (MAX_ITER < 1 || MAX_ITER >= (1 << ITER_W) || WDOG_CYC < 1) begin : g_bad_param
    $error("ica_iter_ctrl: illegal MAX_ITER/ITER_W/WDOG_CYC combination");
  end

  state_t                   r_state, w_state_next;
  logic [ITER_W-1:0]        r_iter_cnt;
  logic                     r_en_update, r_busy, r_done, r_converged, r_conv_smp;
  logic                     w_start_ok, w_smp_load, w_ica_load, w_wdog_trip, w_fault;
  logic signed [DATA_W-1:0] w_init_a [N_W];
  logic signed [DATA_W-1:0] w_in_a   [N_W];
  logic signed [DATA_W-1:0] w_smp_q  [N_W];
  logic signed [DATA_W-1:0] w_ica_q  [N_W];

  assign w_init_a   = bus.w_init;
  assign w_in_a     = bus.w;
  assign w_start_ok = bus.start && (r_state == IDLE || r_state == DONE);
  // Error-stage result is captured on the first idle cycle of WAIT_DONE.
  assign w_smp_load = (r_state == WAIT_DONE) && !bus.error_busy;
  // w_ica takes w_init on start and the sampled matrix on every DECIDE.
  assign w_ica_load = w_start_ok || (r_state == DECIDE);

`ifdef ICA_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYC + 1);
  logic [WDOG_W-1:0] r_wdog_cnt;
  logic              r_fault;

  // Per-wait-state cycle counter, restarted on every state change.
  always_ff @(posedge clk_iter or negedge rstn_iter) begin
    if (!rstn_iter) begin
      r_wdog_cnt <= '0;
    end else if (w_state_next != r_state) begin
      r_wdog_cnt <= '0;
    end else if (r_state == WAIT_BUSY || r_state == WAIT_DONE) begin
      r_wdog_cnt <= r_wdog_cnt + 1'b1;
    end
  end

  assign w_wdog_trip = ((r_state == WAIT_BUSY && !bus.error_busy) ||
                        (r_state == WAIT_DONE &&  bus.error_busy)) &&
                       (r_wdog_cnt == WDOG_W'(WDOG_CYC - 1));

  // Fault flag: set by a watchdog abort, cleared by the next accepted start.
  always_ff @(posedge clk_iter or negedge rstn_iter) begin
    if (!rstn_iter) begin
      r_fault <= 1'b0;
    end else if (w_start_ok) begin
      r_fault <= 1'b0;
    end else if (w_wdog_trip) begin
      r_fault <= 1'b1;
    end
  end

  assign w_fault = r_fault;
`else
  assign w_wdog_trip = 1'b0;
  assign w_fault     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_iter or negedge rstn_iter) begin
    if (!rstn_iter) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, DONE: if (bus.start) w_state_next = LAUNCH;
      LAUNCH:     w_state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (bus.error_busy)   w_state_next = WAIT_DONE;
        else if (w_wdog_trip) w_state_next = DONE;
      end
      WAIT_DONE: begin
        if (!bus.error_busy)  w_state_next = DECIDE;
        else if (w_wdog_trip) w_state_next = DONE;
      end
      DECIDE: begin
        // Convergence wins over the iteration limit.
        if (r_conv_smp || r_iter_cnt == ITER_W'(MAX_ITER)) w_state_next = DONE;
        else                                               w_state_next = LAUNCH;
      end
      default:    w_state_next = IDLE;
    endcase
  end

  // Registered status outputs, iteration counter and sampled convergence flag.
  always_ff @(posedge clk_iter or negedge rstn_iter) begin
    if (!rstn_iter) begin
      r_en_update <= 1'b0;
      r_iter_cnt  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_converged <= 1'b0;
      r_conv_smp  <= 1'b0;
    end else begin
      r_en_update <= (w_state_next == LAUNCH);
      if (w_smp_load) r_conv_smp <= bus.isConverge;
      if (w_start_ok) begin
        r_iter_cnt  <= '0;
        r_busy      <= 1'b1;
        r_done      <= 1'b0;
        r_converged <= 1'b0;
      end else if (r_state == LAUNCH) begin
        r_iter_cnt <= r_iter_cnt + 1'b1;
      end
      if (w_state_next == DONE && r_state != DONE) begin
        r_busy      <= 1'b0;
        r_done      <= 1'b1;
        r_converged <= (r_state == DECIDE) && r_conv_smp;
      end
    end
  end

  ica_weight_reg #(.DATA_W(DATA_W)) u_smp_bank (
    .i_clk      (clk_iter),
    .i_rst_n    (rstn_iter),
    .i_load     (w_smp_load),
    .i_sel_init (1'b0),
    .i_d_init   (w_init_a),
    .i_d_alt    (w_in_a),
    .o_q        (w_smp_q)
  );

  ica_weight_reg #(.DATA_W(DATA_W)) u_ica_bank (
    .i_clk      (clk_iter),
    .i_rst_n    (rstn_iter),
    .i_load     (w_ica_load),
    .i_sel_init (w_start_ok),
    .i_d_init   (w_init_a),
    .i_d_alt    (w_smp_q),
    .o_q        (w_ica_q)
  );

  assign bus.en_update = r_en_update;
  assign bus.w_ica     = w_ica_q;
  assign bus.iter_cnt  = r_iter_cnt;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.converged = r_converged;
  assign bus.fault     = w_fault;

endmodule
